// File: rtl/unsaved_onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip RAM.
// Tracks the RAM's 1-cycle read latency and routes read data to its issuer.
module unsaved_onchip_mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [CNT_W-1:0]  conflict_count
);

  logic m0_req;
  logic m1_req;
  logic grant0;
  logic grant1;
  logic last_grant;
  logic rd_pend;
  logic rd_owner;
  logic rd_accept;
  logic win_write;

  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;

  // last_grant holds the index of the previous winner
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (m0_req && m1_req) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = m0_req;
        grant1 = m1_req;
      end
    end
  end

  assign m0_waitrequest = reset | (m0_req & ~grant0);
  assign m1_waitrequest = reset | (m1_req & ~grant1);

  assign win_write = grant1 ? m1_write : m0_write;

  // read and write together counts as a write
  assign rd_accept = (grant0 & m0_read & ~m0_write)
                   | (grant1 & m1_read & ~m1_write);

  always_comb begin
    mem_chipselect = grant0 | grant1;
    mem_write      = (grant0 | grant1) & win_write;
    mem_address    = grant1 ? m1_address : m0_address;
    mem_writedata  = grant1 ? m1_writedata : m0_writedata;
    mem_byteenable = {BE_W{1'b1}};
    if (win_write)
      mem_byteenable = grant1 ? m1_byteenable : m0_byteenable;
  end

  assign mem_clken = ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant     <= 1'b1;
      rd_pend        <= 1'b0;
      rd_owner       <= 1'b0;
      conflict_count <= '0;
    end else begin
      if (grant0 | grant1)
        last_grant <= grant1;
      rd_pend  <= rd_accept;
      rd_owner <= grant1;
      if (m0_req && m1_req && !(&conflict_count))
        conflict_count <= conflict_count + 1'b1;
    end
  end

  // reset gating drops a read that was in flight when reset arrived
  assign m0_readdatavalid = ~reset & rd_pend & ~rd_owner;
  assign m1_readdatavalid = ~reset & rd_pend & rd_owner;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_unsaved_onchip_mem_arbiter.sv
// Bench for the two-master RAM arbiter: RAM model, scoreboard queues,
// directed vectors and a short burst of random two-master traffic.
module tb_unsaved_onchip_mem_arbiter;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] m0_address, m1_address;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [BW-1:0] m0_byteenable, m1_byteenable;
  logic [DW-1:0] m0_writedata, m1_writedata;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;
  logic [CW-1:0] conflict_count;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] refm [0:(1<<AW)-1];
  logic          init_ram;
  logic [DW-1:0] exp0[$];
  logic [DW-1:0] exp1[$];

  always #5 clk = ~clk;

  unsaved_onchip_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .conflict_count(conflict_count)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                          input logic [DW-1:0] d,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++)
      if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // single-port RAM with registered read data
  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < (1<<AW); i++)
        ram[i] <= 32'hC0DE0000 | DW'(i);
    end else if (mem_clken && mem_chipselect) begin
      if (mem_write)
        ram[mem_address] <= merge(ram[mem_address], mem_writedata,
                                  mem_byteenable);
      else
        mem_readdata <= ram[mem_address];
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      assert (!(m0_read && m0_write)) else $error("m0 read and write both high");
      assert (!(m1_read && m1_write)) else $error("m1 read and write both high");
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (m0_readdatavalid) begin
      checks++;
      if (exp0.size() == 0) begin
        failures++;
        $display("FAIL m0_unexpected_valid got=%h required=none", m0_readdata);
      end else begin
        logic [DW-1:0] e;
        e = exp0.pop_front();
        if (m0_readdata !== e) begin
          failures++;
          $display("FAIL m0_readdata got=%h required=%h", m0_readdata, e);
        end
      end
    end
    if (m1_readdatavalid) begin
      checks++;
      if (exp1.size() == 0) begin
        failures++;
        $display("FAIL m1_unexpected_valid got=%h required=none", m1_readdata);
      end else begin
        logic [DW-1:0] e;
        e = exp1.pop_front();
        if (m1_readdata !== e) begin
          failures++;
          $display("FAIL m1_readdata got=%h required=%h", m1_readdata, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, act, req);
    end
  endtask

  task automatic m0_xfer(input logic wr, input logic [AW-1:0] a,
                         input logic [BW-1:0] be, input logic [DW-1:0] d,
                         input logic [DW-1:0] e, input bit use_ref);
    int n;
    bit acc;
    m0_read = !wr; m0_write = wr; m0_address = a;
    m0_byteenable = be; m0_writedata = d;
    n = 0; acc = 0;
    while (!acc && n < 1000) begin
      @(negedge clk);
      if (!m0_waitrequest) acc = 1;
      else n++;
    end
    if (!acc) begin
      checks++; failures++;
      $display("FAIL m0_accept_timeout got=stalled required=accept");
    end else if (wr) refm[a] = merge(refm[a], d, be);
    else exp0.push_back(use_ref ? refm[a] : e);
    @(posedge clk); #1;
    m0_read = 0; m0_write = 0;
  endtask

  task automatic m1_xfer(input logic wr, input logic [AW-1:0] a,
                         input logic [BW-1:0] be, input logic [DW-1:0] d,
                         input logic [DW-1:0] e, input bit use_ref);
    int n;
    bit acc;
    m1_read = !wr; m1_write = wr; m1_address = a;
    m1_byteenable = be; m1_writedata = d;
    n = 0; acc = 0;
    while (!acc && n < 1000) begin
      @(negedge clk);
      if (!m1_waitrequest) acc = 1;
      else n++;
    end
    if (!acc) begin
      checks++; failures++;
      $display("FAIL m1_accept_timeout got=stalled required=accept");
    end else if (wr) refm[a] = merge(refm[a], d, be);
    else exp1.push_back(use_ref ? refm[a] : e);
    @(posedge clk); #1;
    m1_read = 0; m1_write = 0;
  endtask

  // both masters hold a read for n cycles; winner alternates starting at m0
  task automatic both_read(input int n, input logic [AW-1:0] a0,
                           input logic [AW-1:0] a1, input logic [DW-1:0] d0,
                           input logic [DW-1:0] d1);
    bit w0;
    w0 = 1;
    m0_read = 1; m1_read = 1; m0_address = a0; m1_address = a1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("both_m0_wait", 32'(m0_waitrequest), 32'(!w0));
      chk("both_m1_wait", 32'(m1_waitrequest), 32'(w0));
      if (w0) exp0.push_back(d0);
      else exp1.push_back(d1);
      w0 = !w0;
      @(posedge clk); #1;
    end
    m0_read = 0; m1_read = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    reset = 1; init_ram = 1;
    m0_address = '0; m0_read = 0; m0_write = 0;
    m0_byteenable = '0; m0_writedata = '0;
    m1_address = '0; m1_read = 0; m1_write = 0;
    m1_byteenable = '0; m1_writedata = '0;
    for (int i = 0; i < (1<<AW); i++)
      refm[i] = 32'hC0DE0000 | DW'(i);
    @(posedge clk); #1;
    init_ram = 0;
    @(negedge clk);
    chk("reset_m0_wait", 32'(m0_waitrequest), 32'd1);
    chk("reset_m1_wait", 32'(m1_waitrequest), 32'd1);
    chk("reset_clken", 32'(mem_clken), 32'd0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("init_m0_wait", 32'(m0_waitrequest), 32'd0);
    chk("init_m1_wait", 32'(m1_waitrequest), 32'd0);
    chk("init_valids", 32'({m0_readdatavalid, m1_readdatavalid}), 32'd0);
    chk("init_count", 32'(conflict_count), 32'd0);
    chk("init_cs", 32'(mem_chipselect), 32'd0);
    chk("init_clken", 32'(mem_clken), 32'd1);
    @(posedge clk); #1;

    // lone m0 read
    m0_xfer(0, 13'h010, 4'hF, 32'h0, 32'hC0DE0010, 0);
    idle(2);

    // four cycles of simultaneous reads from a fresh reset
    do_reset();
    both_read(4, 13'h001, 13'h101, 32'hC0DE0001, 32'hC0DE0101);
    idle(2);
    @(negedge clk);
    chk("conflict_count_4", 32'(conflict_count), 32'd4);
    @(posedge clk); #1;

    // partial write then read-after-write
    m1_xfer(1, 13'h020, 4'b0011, 32'hDEADBEEF, 32'h0, 0);
    m0_xfer(0, 13'h020, 4'hF, 32'h0, 32'hC0DEBEEF, 0);
    idle(2);

    // reset lands while an m1 read is in flight
    m1_read = 1; m1_address = 13'h040;
    @(negedge clk);
    chk("rst_mid_m1_accept", 32'(m1_waitrequest), 32'd0);
    @(posedge clk); #1;
    reset = 1; m1_read = 0;
    @(negedge clk);
    chk("rst_mid_m1_valid", 32'(m1_readdatavalid), 32'd0);
    chk("rst_mid_waits", 32'({m0_waitrequest, m1_waitrequest}), 32'd3);
    chk("rst_mid_cs", 32'(mem_chipselect), 32'd0);
    chk("rst_mid_clken", 32'(mem_clken), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0;
    both_read(2, 13'h030, 13'h130, 32'hC0DE0030, 32'hC0DE0130);
    idle(2);

    // counter saturation at all-ones
    do_reset();
    both_read(14, 13'h050, 13'h150, 32'hC0DE0050, 32'hC0DE0150);
    @(negedge clk);
    chk("conflict_count_14", 32'(conflict_count), 32'd14);
    @(posedge clk); #1;
    both_read(3, 13'h051, 13'h151, 32'hC0DE0051, 32'hC0DE0151);
    idle(1);
    @(negedge clk);
    chk("conflict_count_sat", 32'(conflict_count), 32'd15);
    @(posedge clk); #1;

    // random two-master traffic on a shared small window
    fork
      begin
        for (int k = 0; k < 250; k++) begin
          idle($urandom_range(0, 2));
          m0_xfer(1'($urandom_range(0, 1)), 13'h200 + 13'($urandom_range(0, 15)),
                  4'($urandom_range(1, 15)), $urandom, 32'h0, 1);
        end
      end
      begin
        for (int k = 0; k < 250; k++) begin
          idle($urandom_range(0, 2));
          m1_xfer(1'($urandom_range(0, 1)), 13'h200 + 13'($urandom_range(0, 15)),
                  4'($urandom_range(1, 15)), $urandom, 32'h0, 1);
        end
      end
    join
    idle(4);
    @(negedge clk);
    chk("m0_queue_drained", 32'(exp0.size()), 32'd0);
    chk("m1_queue_drained", 32'(exp1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
